br_lite_tx_if: RTL and testbench

//  Per-PE injection interface feeding one BrLiteNoC local port (flit_i/req_i/ack_o/busy_o).

---
 rtl/br_lite_tx_if.sv | 170 +++++++++++++++++
 tb/tb_br_lite_tx_if.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_lite_tx_if.sv
// rtl/br_lite_tx_if.sv - per-PE BrLiteNoC injection interface with request FIFO and req/ack handshake
//
// Queues PE service requests in a DEPTH-entry FIFO, stamps each sent message with a
// wrapping sequence id and presents it to the NoC local port one message at a time.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   in_valid_i / in_ready_o           PE push handshake (in_ready_o == !full)
//   in_src_i, in_tgt_i, in_payload_i, in_svc_i   message fields
//   busy_i                            NoC local slot busy, sampled only in IDLE
//   req_o / ack_i                     NoC request / acknowledge
//   flit_src_o .. flit_id_o           flit fields, held stable while req_o is high
//   count_o                           FIFO occupancy
//   idle_o                            FIFO empty and FSM idle

module br_lite_tx_if #(
    parameter int DEPTH     = 4,
    parameter int SRC_W     = 16,
    parameter int TGT_W     = 16,
    parameter int PAYLOAD_W = 32,
    parameter int SVC_W     = 2,
    parameter int ID_W      = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [SRC_W-1:0]           in_src_i,
    input  logic [TGT_W-1:0]           in_tgt_i,
    input  logic [PAYLOAD_W-1:0]       in_payload_i,
    input  logic [SVC_W-1:0]           in_svc_i,
    input  logic                       busy_i,
    output logic                       req_o,
    input  logic                       ack_i,
    output logic [SRC_W-1:0]           flit_src_o,
    output logic [TGT_W-1:0]           flit_tgt_o,
    output logic [PAYLOAD_W-1:0]       flit_pay_o,
    output logic [SVC_W-1:0]           flit_svc_o,
    output logic [ID_W-1:0]            flit_id_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       idle_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SRC_W-1:0]     mem_src [DEPTH];
    logic [TGT_W-1:0]     mem_tgt [DEPTH];
    logic [PAYLOAD_W-1:0] mem_pay [DEPTH];
    logic [SVC_W-1:0]     mem_svc [DEPTH];

    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [ID_W-1:0] id_q;

    logic full;
    logic push;
    logic pop;
    logic load;

    assign full       = (count_q == CW'(DEPTH));
    assign push       = in_valid_i && !full;
    assign in_ready_o = !full;
    assign count_o    = count_q;
    assign req_o      = (state_q == S_REQ);
    assign idle_o     = (count_q == '0) && (state_q == S_IDLE);

    // FIFO storage: no reset needed, validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_src[wr_ptr_q] <= in_src_i;
            mem_tgt[wr_ptr_q] <= in_tgt_i;
            mem_pay[wr_ptr_q] <= in_payload_i;
            mem_svc[wr_ptr_q] <= in_svc_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && !busy_i) begin
                    load    = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_i) begin
                    pop     = 1'b1;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // Going through IDLE after ack falls guarantees req_o stays low
                // in the cycle the ack drops.
                if (!ack_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Flit fields are captured once on entry to REQ and then held, so busy_i
    // or pushes during REQ cannot disturb the offered message.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_src_o <= '0;
            flit_tgt_o <= '0;
            flit_pay_o <= '0;
            flit_svc_o <= '0;
            flit_id_o  <= '0;
            id_q       <= '0;
        end else begin
            if (load) begin
                flit_src_o <= mem_src[rd_ptr_q];
                flit_tgt_o <= mem_tgt[rd_ptr_q];
                flit_pay_o <= mem_pay[rd_ptr_q];
                flit_svc_o <= mem_svc[rd_ptr_q];
                flit_id_o  <= id_q;
            end
            if (pop) begin
                id_q <= id_q + ID_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_br_lite_tx_if.sv
// tb/tb_br_lite_tx_if.sv - self-checking bench for br_lite_tx_if

module tb_br_lite_tx_if;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] src;
        logic [15:0] tgt;
        logic [31:0] pay;
        logic [1:0]  svc;
    } msg_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] in_src_i;
    logic [15:0] in_tgt_i;
    logic [31:0] in_payload_i;
    logic [1:0]  in_svc_i;
    logic        busy_i;
    logic        req_o;
    logic        ack_i;
    logic [15:0] flit_src_o;
    logic [15:0] flit_tgt_o;
    logic [31:0] flit_pay_o;
    logic [1:0]  flit_svc_o;
    logic [4:0]  flit_id_o;
    logic [2:0]  count_o;
    logic        idle_o;

    int   vectors;
    int   miscompares;
    msg_t q[$];
    int   exp_id;

    br_lite_tx_if dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_src_i     (in_src_i),
        .in_tgt_i     (in_tgt_i),
        .in_payload_i (in_payload_i),
        .in_svc_i     (in_svc_i),
        .busy_i       (busy_i),
        .req_o        (req_o),
        .ack_i        (ack_i),
        .flit_src_o   (flit_src_o),
        .flit_tgt_o   (flit_tgt_o),
        .flit_pay_o   (flit_pay_o),
        .flit_svc_o   (flit_svc_o),
        .flit_id_o    (flit_id_o),
        .count_o      (count_o),
        .idle_o       (idle_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic msg_t rand_msg();
        msg_t m;
        m.src = 16'($urandom);
        m.tgt = 16'($urandom);
        m.pay = $urandom;
        m.svc = 2'($urandom_range(0, 3));
        return m;
    endfunction

    task automatic apply_reset(input int n);
        rst_n      = 1'b0;
        in_valid_i = 1'b0;
        ack_i      = 1'b0;
        busy_i     = 1'b0;
        q.delete();
        exp_id = 0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; offers one message for one cycle.
    task automatic push_msg(input msg_t m);
        in_valid_i   = 1'b1;
        in_src_i     = m.src;
        in_tgt_i     = m.tgt;
        in_payload_i = m.pay;
        in_svc_i     = m.svc;
        chk("in_ready", 64'(in_ready_o), 64'(q.size() < DEPTH));
        if (q.size() < DEPTH) q.push_back(m);
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    task automatic check_flit(input string tag);
        if (q.size() == 0) begin
            chk({tag, "_model_nonempty"}, 64'(0), 64'(1));
        end else begin
            chk({tag, "_src"}, 64'(flit_src_o), 64'(q[0].src));
            chk({tag, "_tgt"}, 64'(flit_tgt_o), 64'(q[0].tgt));
            chk({tag, "_pay"}, 64'(flit_pay_o), 64'(q[0].pay));
            chk({tag, "_svc"}, 64'(flit_svc_o), 64'(q[0].svc));
            chk({tag, "_id"},  64'(flit_id_o),  64'(exp_id));
        end
    endtask

    // Waits (bounded) for req_o, checks the head message, acks with a level of
    // ack_len cycles and checks that exactly one message left the queue.
    task automatic send_one(input int ack_len);
        int waited;
        waited = 0;
        while (req_o !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("req_seen", 64'(req_o), 64'(1));
        if (req_o === 1'b1) begin
            check_flit("send");
            ack_i = 1'b1;
            for (int k = 0; k < ack_len; k++) begin
                @(negedge clk);
                chk("req_low_ack_high", 64'(req_o), 64'(0));
            end
            ack_i = 1'b0;
            void'(q.pop_front());
            exp_id = (exp_id + 1) % 32;
            chk("count_after_pop", 64'(count_o), 64'(q.size()));
            @(negedge clk);
            chk("req_low_ack_drop", 64'(req_o), 64'(0));
        end
    endtask

    initial begin
        msg_t m;
        int   sent;
        int   n;
        int   waited;

        vectors      = 0;
        miscompares  = 0;
        exp_id       = 0;
        rst_n        = 1'b0;
        in_valid_i   = 1'b0;
        ack_i        = 1'b0;
        busy_i       = 1'b0;
        in_src_i     = '0;
        in_tgt_i     = '0;
        in_payload_i = '0;
        in_svc_i     = '0;

        // T1 reset
        repeat (10) @(negedge clk);
        chk("rst_req",   64'(req_o),      64'(0));
        chk("rst_ready", 64'(in_ready_o), 64'(1));
        chk("rst_count", 64'(count_o),    64'(0));
        chk("rst_idle",  64'(idle_o),     64'(1));
        chk("rst_flit",  64'({flit_src_o, flit_tgt_o, flit_id_o}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // T2 single message
        m.src = 16'h0102; m.tgt = 16'h0000; m.pay = 32'hDEADBEEF; m.svc = 2'd0;
        push_msg(m);
        chk("t2_req_not_yet", 64'(req_o),   64'(0));
        chk("t2_count1",      64'(count_o), 64'(1));
        @(negedge clk);
        chk("t2_req_rise", 64'(req_o), 64'(1));
        check_flit("t2");
        repeat (2) @(negedge clk);
        chk("t2_req_held", 64'(req_o), 64'(1));
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
        void'(q.pop_front());
        exp_id = 1;
        chk("t2_req_drop", 64'(req_o),   64'(0));
        chk("t2_count0",   64'(count_o), 64'(0));
        @(negedge clk);
        chk("t2_idle", 64'(idle_o), 64'(1));

        // T3 busy gate
        busy_i = 1'b1;
        push_msg(rand_msg());
        for (int i = 0; i < 20; i++) begin
            chk("t3_busy_block", 64'(req_o), 64'(0));
            @(negedge clk);
        end
        busy_i = 1'b0;
        @(negedge clk);
        chk("t3_req_after_busy", 64'(req_o), 64'(1));
        busy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_msg(rand_msg());
            chk("t3_req_held_busy", 64'(req_o), 64'(1));
            check_flit("t3_stable");
        end
        send_one(1);
        busy_i = 1'b0;
        while (q.size() > 0) send_one(1);

        // T4 full FIFO, ordering, ids 0..3
        apply_reset(3);
        for (int i = 0; i < 5; i++) push_msg(rand_msg());
        chk("t4_count_full", 64'(count_o),    64'(DEPTH));
        chk("t4_ready_low",  64'(in_ready_o), 64'(0));
        for (int i = 0; i < 4; i++) send_one(1);
        chk("t4_empty", 64'(idle_o), 64'(1));

        // T5 ack outside REQ ignored, then id wrap with random level acks
        apply_reset(3);
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
        @(negedge clk);
        chk("t5_stray_ack_count", 64'(count_o), 64'(0));
        chk("t5_stray_ack_idle",  64'(idle_o),  64'(1));
        sent = 0;
        while (sent < 33) begin
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) begin
                if (q.size() < DEPTH) push_msg(rand_msg());
            end
            if (q.size() > 0) begin
                send_one((sent % 5 == 0) ? 4 : $urandom_range(1, 4));
                sent++;
            end
        end
        while (q.size() > 0) send_one(1);

        // T6 reset while requesting
        push_msg(rand_msg());
        push_msg(rand_msg());
        waited = 0;
        while (req_o !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("t6_req_before_reset", 64'(req_o), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("t6_req_async_drop", 64'(req_o),   64'(0));
        chk("t6_count_cleared",  64'(count_o), 64'(0));
        q.delete();
        exp_id = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_count_after", 64'(count_o), 64'(0));
        chk("t6_idle_after",  64'(idle_o),  64'(1));
        push_msg(rand_msg());
        send_one(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
